// File: rtl/decode_execute_if.sv
// decode_execute_if: Decode-to-Execute pipeline bundle carrying the incoming
// D-stage fields, the registered E-stage fields, and stall/flush/hold controls.
interface decode_execute_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CTRL_WIDTH    = 12,
    parameter int CNT_WIDTH     = 16
);
    logic                     iValidD;
    logic [ADDRESS_WIDTH-1:0] iRs1D;
    logic [ADDRESS_WIDTH-1:0] iRs2D;
    logic [ADDRESS_WIDTH-1:0] iRdD;
    logic [DATA_WIDTH-1:0]    iRegData1D;
    logic [DATA_WIDTH-1:0]    iRegData2D;
    logic [DATA_WIDTH-1:0]    iImmD;
    logic [DATA_WIDTH-1:0]    iPCD;
    logic [DATA_WIDTH-1:0]    iPCPlus4D;
    logic [CTRL_WIDTH-1:0]    iCtrlD;
    logic                     iFlush;
    logic                     iHold;
    logic                     oValidE;
    logic [ADDRESS_WIDTH-1:0] oRs1E;
    logic [ADDRESS_WIDTH-1:0] oRs2E;
    logic [ADDRESS_WIDTH-1:0] oRdE;
    logic [DATA_WIDTH-1:0]    oRegData1E;
    logic [DATA_WIDTH-1:0]    oRegData2E;
    logic [DATA_WIDTH-1:0]    oImmE;
    logic [DATA_WIDTH-1:0]    oPCE;
    logic [DATA_WIDTH-1:0]    oPCPlus4E;
    logic [CTRL_WIDTH-1:0]    oCtrlE;
    logic                     oStallD;
    logic [CNT_WIDTH-1:0]     oBubbleCount;

    modport master (
        output iValidD, iRs1D, iRs2D, iRdD, iRegData1D, iRegData2D, iImmD, iPCD, iPCPlus4D, iCtrlD,
               iFlush, iHold,
        input  oValidE, oRs1E, oRs2E, oRdE, oRegData1E, oRegData2E, oImmE, oPCE, oPCPlus4E, oCtrlE,
               oStallD, oBubbleCount
    );

    modport slave (
        input  iValidD, iRs1D, iRs2D, iRdD, iRegData1D, iRegData2D, iImmD, iPCD, iPCPlus4D, iCtrlD,
               iFlush, iHold,
        output oValidE, oRs1E, oRs2E, oRdE, oRegData1E, oRegData2E, oImmE, oPCE, oPCPlus4E, oCtrlE,
               oStallD, oBubbleCount
    );
endinterface

// File: rtl/decode_execute_stage.sv
// decode_execute_stage: D/E pipeline register with load-use hazard detection,
// bubble insertion, flush/hold handling and a saturating bubble counter.
module decode_execute_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CTRL_WIDTH    = 12,
    parameter int CNT_WIDTH     = 16
) (
    input logic               iClk,
    input logic               iRstN,
    decode_execute_if.slave   bus
);
    typedef struct packed {
        logic                     valid;
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data1;
        logic [DATA_WIDTH-1:0]    data2;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    pc;
        logic [DATA_WIDTH-1:0]    pc_plus4;
        logic [CTRL_WIDTH-1:0]    ctrl;
    } stage_t;

    stage_t               e_q, e_d, d_in;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 hazard;
    logic                 count_bubble;

    assign d_in = '{valid: bus.iValidD, rs1: bus.iRs1D, rs2: bus.iRs2D, rd: bus.iRdD,
                    data1: bus.iRegData1D, data2: bus.iRegData2D, imm: bus.iImmD,
                    pc: bus.iPCD, pc_plus4: bus.iPCPlus4D, ctrl: bus.iCtrlD};

    // A bubble in E (valid = 0) never matches, so a load-use stall lasts one cycle.
    assign hazard = e_q.valid & e_q.ctrl[1] & (|e_q.rd) & bus.iValidD &
                    ((e_q.rd == bus.iRs1D) | (e_q.rd == bus.iRs2D));

    assign count_bubble = hazard & ~bus.iFlush & ~bus.iHold;

    always_comb begin
        e_d   = bus.iFlush ? '0 : bus.iHold ? e_q : hazard ? '0 : d_in;
        cnt_d = (count_bubble && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.oValidE      = e_q.valid;
    assign bus.oRs1E        = e_q.rs1;
    assign bus.oRs2E        = e_q.rs2;
    assign bus.oRdE         = e_q.rd;
    assign bus.oRegData1E   = e_q.data1;
    assign bus.oRegData2E   = e_q.data2;
    assign bus.oImmE        = e_q.imm;
    assign bus.oPCE         = e_q.pc;
    assign bus.oPCPlus4E    = e_q.pc_plus4;
    assign bus.oCtrlE       = e_q.ctrl;
    assign bus.oStallD      = bus.iHold | (hazard & ~bus.iFlush);
    assign bus.oBubbleCount = cnt_q;
endmodule

// File: tb/tb_decode_execute_stage.sv
// tb_decode_execute_stage: directed and randomized checks of the D/E stage
// against a field-level reference model of the pipeline register.
module tb_decode_execute_stage;
    localparam int DW = 32, AW = 5, CW = 12, NW = 4;
    localparam int CNT_MAX = (1 << NW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    decode_execute_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

    decode_execute_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .iClk (clk),
        .iRstN(rst_n),
        .bus  (bus.slave)
    );

    // Reference model: expected contents of the Execute-side registers.
    logic          m_v;
    logic [AW-1:0] m_rs1, m_rs2, m_rd;
    logic [DW-1:0] m_d1, m_d2, m_imm, m_pc, m_pc4;
    logic [CW-1:0] m_ctrl;
    int            m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_hazard();
        return m_v && m_ctrl[1] && (m_rd != 0) && bus.iValidD &&
               (m_rd == bus.iRs1D || m_rd == bus.iRs2D);
    endfunction

    task automatic model_clear();
        {m_v, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_pc, m_pc4, m_ctrl} = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(bus.oValidE), 64'(m_v));
        check({tag, ".rs1"},   64'(bus.oRs1E), 64'(m_rs1));
        check({tag, ".rs2"},   64'(bus.oRs2E), 64'(m_rs2));
        check({tag, ".rd"},    64'(bus.oRdE), 64'(m_rd));
        check({tag, ".d1"},    64'(bus.oRegData1E), 64'(m_d1));
        check({tag, ".d2"},    64'(bus.oRegData2E), 64'(m_d2));
        check({tag, ".imm"},   64'(bus.oImmE), 64'(m_imm));
        check({tag, ".pc"},    64'(bus.oPCE), 64'(m_pc));
        check({tag, ".pc4"},   64'(bus.oPCPlus4E), 64'(m_pc4));
        check({tag, ".ctrl"},  64'(bus.oCtrlE), 64'(m_ctrl));
        check({tag, ".stall"}, 64'(bus.oStallD), 64'(bus.iHold | (exp_hazard() & ~bus.iFlush)));
        check({tag, ".cnt"},   64'(bus.oBubbleCount), 64'(m_cnt));
    endtask

    task automatic set_d(input logic v, input int rs1, input int rs2, input int rd,
                         input logic [CW-1:0] ctrl, input logic fl, input logic hd);
        bus.iValidD    = v;
        bus.iRs1D      = AW'(rs1);
        bus.iRs2D      = AW'(rs2);
        bus.iRdD       = AW'(rd);
        bus.iRegData1D = $urandom;
        bus.iRegData2D = $urandom;
        bus.iImmD      = $urandom;
        bus.iPCD       = $urandom & 32'hFFFF_FFFC;
        bus.iPCPlus4D  = bus.iPCD + 32'd4;
        bus.iCtrlD     = ctrl;
        bus.iFlush     = fl;
        bus.iHold      = hd;
    endtask

    // One clock edge: the model applies reset > flush > hold > hazard > advance.
    task automatic step(input string tag);
        bit hz;
        hz = exp_hazard();
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
            m_cnt = 0;
        end else if (bus.iFlush) model_clear();
        else if (bus.iHold) begin
        end else if (hz) begin
            model_clear();
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
            m_v = bus.iValidD; m_rs1 = bus.iRs1D; m_rs2 = bus.iRs2D; m_rd = bus.iRdD;
            m_d1 = bus.iRegData1D; m_d2 = bus.iRegData2D; m_imm = bus.iImmD;
            m_pc = bus.iPCD; m_pc4 = bus.iPCPlus4D; m_ctrl = bus.iCtrlD;
        end
        #1;
        check_all(tag);
    endtask

    task automatic load_use(input string tag);
        set_d(1, 0, 0, 5, 12'h003, 0, 0);
        step({tag, ".ld"});
        set_d(1, 1, 5, 9, 12'h001, 0, 0);
        #1 check({tag, ".stall_on"}, 64'(bus.oStallD), 64'd1);
        step({tag, ".bubble"});
        check({tag, ".bub_v"}, 64'(bus.oValidE), 64'd0);
        check({tag, ".stall_off"}, 64'(bus.oStallD), 64'd0);
        step({tag, ".adv"});
        check({tag, ".adv_rd"}, 64'(bus.oRdE), 64'd9);
    endtask

    initial begin
        int c0;
        model_clear();
        m_cnt = 0;
        set_d(0, 0, 0, 0, '0, 0, 0);
        #2 check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        set_d(1, 1, 2, 7, 12'h001, 0, 0);
        bus.iRegData1D = 32'hDEADBEEF;
        step("normal");
        check("normal.rd_const", 64'(bus.oRdE), 64'd7);
        check("normal.d1_const", 64'(bus.oRegData1E), 64'hDEADBEEF);

        load_use("lu");
        check("lu.cnt_const", 64'(bus.oBubbleCount), 64'd1);

        set_d(1, 0, 0, 0, 12'h003, 0, 0);
        step("x0.ld");
        set_d(1, 0, 3, 4, 12'h001, 0, 0);
        #1 check("x0.stall", 64'(bus.oStallD), 64'd0);
        set_d(1, 0, 0, 5, 12'h001, 0, 0);
        step("nl.ld");
        set_d(1, 5, 0, 6, 12'h001, 0, 0);
        #1 check("nl.stall", 64'(bus.oStallD), 64'd0);

        set_d(1, 0, 0, 5, 12'h003, 0, 0);
        step("pf.ld");
        c0 = m_cnt;
        set_d(1, 5, 0, 6, 12'h001, 1, 0);
        #1 check("pf.stall", 64'(bus.oStallD), 64'd0);
        step("pf");
        check("pf.cnt", 64'(bus.oBubbleCount), 64'(c0));

        set_d(1, 0, 0, 5, 12'h003, 0, 0);
        step("ph.ld");
        set_d(1, 5, 0, 6, 12'h001, 0, 1);
        #1 check("ph.stall", 64'(bus.oStallD), 64'd1);
        step("ph");
        check("ph.rd", 64'(bus.oRdE), 64'd5);
        bus.iHold = 1'b0;
        #1 check("ph.rel_stall", 64'(bus.oStallD), 64'd1);
        step("ph.rel");

        set_d(1, 1, 1, 3, 12'h001, 0, 0);
        step("fh.ld");
        set_d(1, 1, 1, 3, 12'h001, 1, 1);
        step("fh");
        check("fh.v", 64'(bus.oValidE), 64'd0);

        for (int i = 0; i < 400; i++) begin
            set_d($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), CW'($urandom) | ($urandom_range(0, 1) ? 12'h002 : 12'h000),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            step("rnd");
        end

        for (int i = 0; i < 17; i++) load_use("sat");
        check("sat.cnt", 64'(bus.oBubbleCount), 64'(CNT_MAX));

        @(negedge clk) rst_n = 1'b0;
        set_d(0, 0, 0, 0, '0, 0, 0);
        step("rst2");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) load_use("pre");
        set_d(1, 0, 0, 5, 12'h003, 0, 0);
        step("pre.ld");
        set_d(1, 1, 5, 9, 12'h001, 0, 0);
        #1 check("async.pre_stall", 64'(bus.oStallD), 64'd1);
        check("async.pre_cnt", 64'(bus.oBubbleCount), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        m_cnt = 0;
        check_all("async");
        @(negedge clk) rst_n = 1'b1;
        step("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
